// File: rtl/rf_multiport.sv
// rf_multiport: multiport register file with prioritised dual write, optional bypass,
// hardwired R0 and a sequential bulk-clear sweep.
module rf_multiport #(
    parameter int AWL     = 5,
    parameter int DWL     = 32,
    parameter int DEPTH   = 2**AWL,
    parameter int NRP     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               WE0,
    input  logic [AWL-1:0]     WA0,
    input  logic [DWL-1:0]     WD0,
    input  logic               WE1,
    input  logic [AWL-1:0]     WA1,
    input  logic [DWL-1:0]     WD1,
    input  logic [NRP*AWL-1:0] RA,
    output logic [NRP*DWL-1:0] RD,
    input  logic               CLR,
    output logic               BUSY,
    output logic               WCOLL
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [AWL:0] LAST = (AWL+1)'(DEPTH - 1);
    localparam logic [AWL:0] ONE  = (AWL+1)'(1);
    logic [DWL-1:0] mem [DEPTH];
    state_t         state, state_n;
    logic [AWL:0]   cnt;
    logic           busy, we0, we1, coll, wcoll;

    // An address is writable/readable only inside the array and, with ZERO_R0, not entry 0
    function automatic logic valid(input logic [AWL-1:0] a);
        return ({1'b0, a} <= LAST) && !(ZERO_R0 != 0 && a == '0);
    endfunction

    assign busy  = state == CLEAR;
    assign we0   = WE0 && !busy && valid(WA0);
    assign we1   = WE1 && !busy && valid(WA1);
    assign coll  = we0 && we1 && WA0 == WA1;
    assign BUSY  = busy;
    assign WCOLL = wcoll;

    always_comb begin
        state_n = state;
        state_n = busy ? (cnt == LAST ? IDLE : CLEAR) : (CLR ? CLEAR : IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt   <= '0;
            wcoll <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= busy ? cnt + ONE : '0;
            wcoll <= coll;
        end
    end

    // Port 1 is assigned last so it wins on a same-address dual write
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[cnt[AWL-1:0]] <= '0;
        end else begin
            if (we0) mem[WA0] <= WD0;
            if (we1) mem[WA1] <= WD1;
        end
    end

    genvar k;
    for (k = 0; k < NRP; k++) begin : g_rd
        logic [AWL-1:0] a;
        logic [DWL-1:0] d;
        assign a = RA[k*AWL +: AWL];
        assign d = (BYPASS != 0 && we1 && WA1 == a) ? WD1 :
                   (BYPASS != 0 && we0 && WA0 == a) ? WD0 : mem[a];
        assign RD[k*DWL +: DWL] = (busy || !valid(a)) ? '0 : d;
    end
endmodule
